// File: rtl/codec_responder.sv
// codec_responder: CODEC-side end of the serial audio link.
// Deserializes the stereo frame driven by the core on SDin and serializes
// locally supplied left/right samples onto SDout, MSB first.
module codec_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             LRCLK,
  input  logic             SDin,
  output logic             SDout,
  input  logic [WIDTH-1:0] lft_tx,
  input  logic [WIDTH-1:0] rht_tx,
  output logic             tx_ld,
  output logic [WIDTH-1:0] lft_rx,
  output logic [WIDTH-1:0] rht_rx,
  output logic             rx_vld,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, lrclk_sync, sdin_sync;
  logic                   sclk_d, lrclk_d;
  logic                   sclk_s, lrclk_s, sdin_s;
  logic                   sclk_rise, sclk_fall, lr_rise, lr_fall;
  logic                   ld_left, ld_right;

  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rht_hold;
  logic [WIDTH-1:0] rx_shift, rx_nxt, lft_pend;
  logic [CW-1:0]    rx_cnt;
  logic             lft_ok;

  // Input synchronizers plus one extra stage for edge detection. These are
  // left out of reset: clearing them while LRCLK is high would fabricate an
  // LRCLK rise right after reset and start a frame mid-channel.
  always_ff @(posedge clk) begin
    sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
    lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], LRCLK};
    sdin_sync  <= {sdin_sync[SYNC_STAGES-2:0], SDin};
    sclk_d     <= sclk_sync[SYNC_STAGES-1];
    lrclk_d    <= lrclk_sync[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign lr_rise   = lrclk_s & ~lrclk_d;
  assign lr_fall   = ~lrclk_s & lrclk_d;

  // Channel state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: frames start on an LRCLK rise, right channel on the fall.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lr_rise) state_nxt = LEFT;
      LEFT:    if (lr_fall) state_nxt = RIGHT;
      RIGHT:   if (lr_rise) state_nxt = LEFT;
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_left  = lr_rise & (state != LEFT);
  assign ld_right = lr_fall & (state == LEFT);
  assign rx_nxt   = {rx_shift[WIDTH-2:0], sdin_s};

  // SDout is the MSB of a zero-filling shifter, so it reads 0 once all
  // WIDTH bits of a channel have been shifted out and until the next load.
  assign SDout = tx_shift[WIDTH-1];

  // Transmit path: capture samples at frame start, load per channel, shift on SCLK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
      rht_hold <= '0;
      tx_ld    <= 1'b0;
    end else begin
      tx_ld <= 1'b0;
      if (ld_left) begin
        tx_shift <= lft_tx;
        rht_hold <= rht_tx;
        tx_ld    <= 1'b1;
      end else if (ld_right) begin
        tx_shift <= rht_hold;
      end else if (sclk_fall && state != IDLE) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Receive path: shift on SCLK rise, check bit count at each channel boundary,
  // publish the left/right pair once both channels completed in one frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift  <= '0;
      rx_cnt    <= '0;
      lft_pend  <= '0;
      lft_ok    <= 1'b0;
      lft_rx    <= '0;
      rht_rx    <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      if (ld_left || ld_right) begin
        if (state != IDLE && rx_cnt != CW'(WIDTH)) frame_err <= 1'b1;
        if (ld_left) lft_ok <= 1'b0;
        if (sclk_rise) begin
          rx_shift <= rx_nxt;
          rx_cnt   <= CW'(1);
        end else begin
          rx_cnt <= '0;
        end
      end else if (sclk_rise && state != IDLE && rx_cnt != CW'(WIDTH)) begin
        rx_shift <= rx_nxt;
        rx_cnt   <= rx_cnt + 1'b1;
        if (rx_cnt == CW'(WIDTH - 1)) begin
          if (state == LEFT) begin
            lft_pend <= rx_nxt;
            lft_ok   <= 1'b1;
          end else if (lft_ok) begin
            lft_rx <= lft_pend;
            rht_rx <= rx_nxt;
            rx_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_responder.sv
// Directed testbench for codec_responder: plays the core side of the link.
module tb_codec_responder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         lrclk = 1'b0;
  logic         sd_drv = 1'b0;
  logic         loop_en = 1'b0;
  logic         sdin, sdout, tx_ld, rx_vld, frame_err;
  logic [W-1:0] lft_tx = '0;
  logic [W-1:0] rht_tx = '0;
  logic [W-1:0] lft_rx, rht_rx;

  int checks = 0;
  int failures = 0;

  // Per-frame observations filled in by run_frame.
  logic [W-1:0] got_l, got_r, vld_l, vld_r;
  int           txld_n, txld_at, vld_n, vld_at, err_at;
  bit           rst_zero, sd_bad;

  assign sdin = loop_en ? sdout : sd_drv;

  always #10 clk = ~clk;

  codec_responder #(.SYNC_STAGES(2), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .SCLK(sclk), .LRCLK(lrclk), .SDin(sdin),
    .SDout(sdout), .lft_tx(lft_tx), .rht_tx(rht_tx), .tx_ld(tx_ld),
    .lft_rx(lft_rx), .rht_rx(rht_rx), .rx_vld(rx_vld), .frame_err(frame_err)
  );

  // One 1024-clk core frame: 16 SCLK periods of 32 clks per channel, LRCLK and
  // data change with SCLK fall; SDout is sampled just before each SCLK rise.
  task automatic run_frame(input logic [W-1:0] l_sd, input logic [W-1:0] r_sd,
                           input int drop_bit, input int rst_cycle,
                           input bit chg, input logic [W-1:0] lft_new);
    int ch, k, ph;
    got_l = '0; got_r = '0; vld_l = '0; vld_r = '0;
    txld_n = 0; txld_at = -1; vld_n = 0; vld_at = -1; err_at = -1;
    rst_zero = 1'b0; sd_bad = 1'b0;
    for (int j = 0; j < 1024; j++) begin
      @(negedge clk);
      ch = j / 512;
      k  = (j % 512) / 32;
      ph = j % 32;
      lrclk = (ch == 0);
      if (ph == 0) begin
        sclk   = 1'b0;
        sd_drv = (ch == 0) ? l_sd[W-1-k] : r_sd[W-1-k];
      end
      if (ph == 16 && !(ch == 0 && k == drop_bit)) begin
        if (ch == 0) got_l[W-1-k] = sdout;
        else         got_r[W-1-k] = sdout;
        sclk = 1'b1;
      end
      rst = (j == rst_cycle);
      if (chg && txld_at >= 0 && j == txld_at + 1) lft_tx = lft_new;
      @(posedge clk);
      #1;
      if (tx_ld) begin
        txld_n++;
        if (txld_at < 0) txld_at = j;
      end
      if (rx_vld) begin
        vld_n++;
        vld_at = j;
        vld_l  = lft_rx;
        vld_r  = rht_rx;
      end
      if (frame_err && err_at < 0) err_at = j;
      if (j == rst_cycle)
        rst_zero = (sdout === 1'b0 && tx_ld === 1'b0 && rx_vld === 1'b0 &&
                    frame_err === 1'b0 && lft_rx === '0 && rht_rx === '0);
      if (rst_cycle >= 0 && j >= rst_cycle && sdout !== 1'b0) sd_bad = 1'b1;
    end
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit idle_bad;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({sdout, tx_ld, rx_vld, frame_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {sdout, tx_ld, rx_vld, frame_err});
    end
    checks++;
    if (lft_rx !== '0 || rht_rx !== '0) begin
      failures++;
      $display("FAIL reset_rx got=%h/%h exp=0000/0000", lft_rx, rht_rx);
    end
    // Partial right channel while idle: must be ignored.
    idle_bad = 1'b0;
    sd_drv = 1'b1;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      sclk = ((j % 32) >= 16);
      @(posedge clk);
      #1;
      if (sdout !== 1'b0 || rx_vld !== 1'b0 || tx_ld !== 1'b0) idle_bad = 1'b1;
    end
    checks++;
    if (idle_bad !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet got=%b exp=0", idle_bad);
    end
  endtask

  task automatic test_rx_basic;
    run_frame(16'hA5C3, 16'h7FFF, -1, -1, 1'b0, '0);
    checks++;
    if (vld_n !== 1 || vld_at !== 1010) begin
      failures++;
      $display("FAIL rx_vld_pulse got=%0d@%0d exp=1@1010", vld_n, vld_at);
    end
    checks++;
    if (vld_l !== 16'hA5C3 || vld_r !== 16'h7FFF) begin
      failures++;
      $display("FAIL rx_data got=%h/%h exp=a5c3/7fff", vld_l, vld_r);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rx_frame_err got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_tx;
    lft_tx = 16'h8001;
    rht_tx = 16'h1234;
    run_frame(16'h0000, 16'h0000, -1, -1, 1'b0, '0);
    checks++;
    if (txld_n !== 1 || txld_at !== 2) begin
      failures++;
      $display("FAIL tx_ld_pulse got=%0d@%0d exp=1@2", txld_n, txld_at);
    end
    checks++;
    if (got_l !== 16'h8001 || got_r !== 16'h1234) begin
      failures++;
      $display("FAIL tx_data got=%h/%h exp=8001/1234", got_l, got_r);
    end
  endtask

  task automatic test_tx_hold;
    lft_tx = 16'h8001;
    rht_tx = 16'h1234;
    run_frame(16'h0000, 16'h0000, -1, -1, 1'b1, 16'hFFFF);
    checks++;
    if (got_l !== 16'h8001 || got_r !== 16'h1234) begin
      failures++;
      $display("FAIL hold_cur got=%h/%h exp=8001/1234", got_l, got_r);
    end
    run_frame(16'h0000, 16'h0000, -1, -1, 1'b0, '0);
    checks++;
    if (got_l !== 16'hFFFF || got_r !== 16'h1234) begin
      failures++;
      $display("FAIL hold_next got=%h/%h exp=ffff/1234", got_l, got_r);
    end
  endtask

  task automatic test_rst_mid;
    lft_tx = 16'h0F0F;
    rht_tx = 16'hC35A;
    run_frame(16'h1357, 16'h2468, -1, 768, 1'b0, '0);
    checks++;
    if (rst_zero !== 1'b1) begin
      failures++;
      $display("FAIL rst_outputs got=%b exp=1", rst_zero);
    end
    checks++;
    if (sd_bad !== 1'b0) begin
      failures++;
      $display("FAIL rst_sdout_quiet got=%b exp=0", sd_bad);
    end
    checks++;
    if (vld_n !== 0 || err_at !== -1) begin
      failures++;
      $display("FAIL rst_no_events got=vld%0d err@%0d exp=vld0 err@-1", vld_n, err_at);
    end
    run_frame(16'h1357, 16'h2468, -1, -1, 1'b0, '0);
    checks++;
    if (got_l !== 16'h0F0F || got_r !== 16'hC35A) begin
      failures++;
      $display("FAIL rst_resume_tx got=%h/%h exp=0f0f/c35a", got_l, got_r);
    end
    checks++;
    if (vld_n !== 1 || vld_l !== 16'h1357 || vld_r !== 16'h2468 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_resume_rx got=%0d %h/%h err%b exp=1 1357/2468 err0",
               vld_n, vld_l, vld_r, frame_err);
    end
  endtask

  task automatic test_frame_err;
    run_frame(16'hFFFF, 16'h0000, 5, -1, 1'b0, '0);
    checks++;
    if (err_at !== 514) begin
      failures++;
      $display("FAIL err_timing got=%0d exp=514", err_at);
    end
    checks++;
    if (vld_n !== 0) begin
      failures++;
      $display("FAIL err_no_vld got=%0d exp=0", vld_n);
    end
    run_frame(16'h0001, 16'h0002, -1, -1, 1'b0, '0);
    checks++;
    if (frame_err !== 1'b1 || err_at !== 0) begin
      failures++;
      $display("FAIL err_sticky got=%b@%0d exp=1@0", frame_err, err_at);
    end
    checks++;
    if (vld_n !== 1 || vld_l !== 16'h0001 || vld_r !== 16'h0002) begin
      failures++;
      $display("FAIL err_good_frame got=%0d %h/%h exp=1 0001/0002", vld_n, vld_l, vld_r);
    end
    pulse_reset();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_loopback;
    logic [W-1:0] lv [4];
    logic [W-1:0] rv [4];
    lv[0] = 16'h1111; rv[0] = 16'hEEEE;
    lv[1] = 16'h8000; rv[1] = 16'h0001;
    lv[2] = 16'h7FFF; rv[2] = 16'h8000;
    lv[3] = 16'hDEAD; rv[3] = 16'hBEEF;
    loop_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      lft_tx = lv[f];
      rht_tx = rv[f];
      run_frame('0, '0, -1, -1, 1'b0, '0);
      checks++;
      if (vld_n !== 1) begin
        failures++;
        $display("FAIL loop%0d_vld got=%0d exp=1", f, vld_n);
      end
      checks++;
      if (vld_l !== lv[f]) begin
        failures++;
        $display("FAIL loop%0d_left got=%h exp=%h", f, vld_l, lv[f]);
      end
      checks++;
      if (vld_r !== rv[f]) begin
        failures++;
        $display("FAIL loop%0d_right got=%h exp=%h", f, vld_r, rv[f]);
      end
    end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx();
    test_tx_hold();
    test_rst_mid();
    test_frame_err();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
